led_blinker: RTL and testbench
==============================

# led_blinker

Multi-channel LED event driver: converts single-cycle event pulses, such as the output of an edge detector, into human-visible LED blinks. Each channel has an on/off timer and a saturating queue of pending blinks, so back-to-back events produce distinct, countable blinks instead of merging. A single shared prescaler sets the time base. The block sits between event-producing logic and the board LED pins.

## Interface
- CHANNELS, 8, number of independent LED channels (1..8)
- TICK_DIV, 50000, clock cycles per timer tick (>=2); 1 ms at 50 MHz
- ON_TICKS, 100, ticks the LED is lit per blink (>=1)
- OFF_TICKS, 100, ticks of dark gap after each blink (>=1)
- MAX_PENDING, 7, maximum queued blinks per channel (>=1)

- CLK  in  1  system clock (CLOCK_50 at top level)
- RST_N  in  1  asynchronous, active-low reset
- EVENT  in  CHANNELS  single-cycle event pulses, one bit per channel, synchronous to CLK
- CLR_OVF  in  1  synchronous clear of all OVERFLOW bits
- LED  out  CHANNELS  registered LED drive, 1 = lit
- BUSY  out  CHANNELS  channel not IDLE
- OVERFLOW  out  CHANNELS  sticky; an event was dropped because the queue was full

## Operation
- **Prescaler.** Free-running counter 0..TICK_DIV-1, reset to 0. TICK is asserted in the cycle where the count equals TICK_DIV-1. It is shared by all channels.
- **Per-channel FSM states.**
  - IDLE: LED=0, BUSY=0.
  - ON: LED=1, BUSY=1.
  - OFF: LED=0, BUSY=1.
- **Timer.** The per-channel timer clears to 0 on entry to ON or OFF and increments on TICK.
- **IDLE transitions.** EVENT -> ON. Pending stays 0.
- **ON transitions.**
  - TICK with timer==ON_TICKS-1 -> OFF.
  - EVENT increments pending.
- **OFF transitions.**
  - EVENT increments pending.
  - On TICK with timer==OFF_TICKS-1, let eff = pending + EVENT.
  - eff>0: go to ON and set pending = eff-1.
  - eff==0: go to IDLE.
- **Pending saturation.**
  - EVENT with pending==MAX_PENDING and no same-cycle decrement: the event is dropped and OVERFLOW is set.
  - EVENT with a same-cycle decrement: pending is unchanged and no overflow is flagged.
- **OVERFLOW.** Set by a dropped event. Cleared by CLR_OVF. If both occur in the same cycle, set wins.
- **Independence.** Channels are fully independent. Simultaneous events on several channels are all accepted.
- **Widths.**
  - pending: $clog2(MAX_PENDING+1) bits.
  - timer: $clog2(max(ON_TICKS,OFF_TICKS)) bits, minimum 1.
  - prescaler: $clog2(TICK_DIV) bits.
  - No counter wraps: all compares are equality against the terminal value, and pending saturates.

## Timing
- **Reset (RST_N low).** Takes effect immediately, asynchronously:
  - LED=0, BUSY=0, OVERFLOW=0.
  - All FSMs in IDLE; pending, timers and prescaler at 0.
  - Reset mid-blink aborts the blink and discards the queue.
- **Event latency.** EVENT sampled high at edge n in IDLE -> LED and BUSY high from cycle n+1.
- **Lit duration.** LED stays lit through the cycle of the ON_TICKS-th TICK after entry. It goes dark the following cycle.
- **Gap duration.** The OFF gap ends the same way after OFF_TICKS ticks.
- **Blink length jitter.** A blink lasts between (ON_TICKS-1)*TICK_DIV+1 and ON_TICKS*TICK_DIV cycles, depending on prescaler phase.
- **Queued blinks.** ON follows OFF with no extra IDLE cycle.
- **Flags.** OVERFLOW is registered: high from the cycle after the dropped event.

## Structure
- **Shared package `led_blinker_pkg`.** Holds:
  - the FSM state encoding: IDLE=2'd0, ON=2'd1, OFF=2'd2;
  - the default TICK_DIV, ON_TICKS, OFF_TICKS and MAX_PENDING constants.
- **Sub-module `led_blink_channel`.** Contains one FSM, timer, pending counter and overflow flag. Its inputs are CLK, RST_N, TICK, EVENT bit and CLR_OVF.
- **Top level.** Holds the prescaler and instantiates CHANNELS copies of `led_blink_channel` in a generate loop.

## Test plan
All scenarios use TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2 and MAX_PENDING=3, with cycle 0 being the first edge after reset release. TICK therefore occurs at cycles 3, 7, 11, 15, 19, 23…

1. **Reset.** Hold RST_N low for 5 cycles with EVENT toggling -> LED, BUSY and OVERFLOW stay 0.
2. **Single event.** EVENT[0] at cycle 1 -> LED[0]=1 for cycles 2..11, then 0. BUSY[0] goes 0 at cycle 20.
3. **Queued event.** EVENT[0] at cycles 1 and 5 -> first blink as in scenario 2. Second LED[0] high for cycles 20..31, and BUSY[0] goes 0 at cycle 40.
4. **Saturation and overflow.**
   - EVENT[0] at cycles 1, 3, 5, 7, 9 -> 4 blinks total, with OVERFLOW[0]=1 from cycle 10.
   - CLR_OVF at cycle 12 -> OVERFLOW[0]=0 from cycle 13.
   - Repeat with CLR_OVF coincident with a dropped event -> OVERFLOW stays 1.
5. **Simultaneous channels.** EVENT=8'h81 at cycle 1 -> LED[0] and LED[7] identical to scenario 2; other LEDs stay 0.
6. **Reset mid-operation.** Pulse RST_N low at cycle 6 of scenario 3 -> LED[0]=0 immediately. After release, no residual blink occurs and pending is 0.

Source files
------------

// File: rtl/led_blinker_pkg.sv
// Shared definitions for the LED event driver: channel FSM encoding and default timing constants.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV    = 50000;
  localparam int DEF_ON_TICKS    = 100;
  localparam int DEF_OFF_TICKS   = 100;
  localparam int DEF_MAX_PENDING = 7;

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: on/off FSM, tick timer, saturating queue of pending blinks and sticky overflow flag.
module led_blink_channel
  import led_blinker_pkg::*;
#(
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_event,
  input  logic i_clr_ovf,
  output logic o_led,
  output logic o_busy,
  output logic o_overflow
);

  localparam int TMR_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int PND_W   = $clog2(MAX_PENDING + 1);

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [PND_W-1:0]   r_pending;
  logic               r_led;
  logic               r_busy;
  logic               r_ovf;

  logic w_on_end, w_off_end, w_off_fire, w_full, w_drop;

  assign w_on_end   = (r_timer == TMR_W'(ON_TICKS - 1));
  assign w_off_end  = (r_timer == TMR_W'(OFF_TICKS - 1));
  assign w_off_fire = (r_state == ST_OFF) && i_tick && w_off_end;
  assign w_full     = (r_pending == PND_W'(MAX_PENDING));
  // An event arriving as the gap ends is consumed by the next blink, so it can never overflow.
  assign w_drop     = i_event && w_full && (r_state != ST_IDLE) && !w_off_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_pending <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_drop | (r_ovf & ~i_clr_ovf);
      case (r_state)
        ST_IDLE: begin
          if (i_event) begin
            r_state <= ST_ON;
            r_timer <= '0;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_ON: begin
          if (i_event && !w_full) r_pending <= r_pending + PND_W'(1);
          if (i_tick) begin
            if (w_on_end) begin
              r_state <= ST_OFF;
              r_timer <= '0;
              r_led   <= 1'b0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (w_off_fire) begin
            r_timer <= '0;
            if (r_pending != '0 || i_event) begin
              r_state   <= ST_ON;
              r_led     <= 1'b1;
              r_pending <= r_pending - PND_W'(!i_event);
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            if (i_event && !w_full) r_pending <= r_pending + PND_W'(1);
            if (i_tick) r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_timer   <= '0;
          r_pending <= '0;
          r_led     <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_led      = r_led;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED event driver: shared tick prescaler feeding CHANNELS independent blink channels.
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_event,
  input  logic                i_clr_ovf,
  output logic [CHANNELS-1:0] o_led,
  output logic [CHANNELS-1:0] o_busy,
  output logic [CHANNELS-1:0] o_overflow
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pre <= '0;
    else          r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_blink_channel #(
      .ON_TICKS    (ON_TICKS),
      .OFF_TICKS   (OFF_TICKS),
      .MAX_PENDING (MAX_PENDING)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_tick     (w_tick),
      .i_event    (i_event[g]),
      .i_clr_ovf  (i_clr_ovf),
      .o_led      (o_led[g]),
      .o_busy     (o_busy[g]),
      .o_overflow (o_overflow[g])
    );
  end

endmodule

// File: tb/tb_led_blinker.sv
// Bench for led_blinker: directed timeline scenarios plus random events against a countdown-style reference model.
module tb_led_blinker;

  localparam int CH   = 8;
  localparam int TD   = 4;
  localparam int ONT  = 3;
  localparam int OFFT = 2;
  localparam int MAXP = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic [CH-1:0] i_event = '0;
  logic [CH-1:0] o_led, o_busy, o_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle / 1 lit / 2 dark, ticks left in phase, queued blinks.
  int            m_phase[CH];
  int            m_left[CH];
  int            m_q[CH];
  logic [CH-1:0] m_ovf;
  int            m_pre;

  led_blinker #(
    .CHANNELS(CH), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .MAX_PENDING(MAXP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_event(i_event), .i_clr_ovf(i_clr_ovf),
    .o_led(o_led), .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_phase[c] = 0; m_left[c] = 0; m_q[c] = 0;
    end
    m_ovf = '0;
    m_pre = 0;
  endtask

  task automatic model_step(input logic [CH-1:0] ev, input logic clr);
    bit tick;
    bit drop;
    int eff;
    tick  = (m_pre == TD - 1);
    m_pre = tick ? 0 : m_pre + 1;
    for (int c = 0; c < CH; c++) begin
      drop = 0;
      case (m_phase[c])
        0: if (ev[c]) begin m_phase[c] = 1; m_left[c] = ONT; end
        1: begin
          if (ev[c]) begin if (m_q[c] < MAXP) m_q[c]++; else drop = 1; end
          if (tick) begin
            m_left[c]--;
            if (m_left[c] == 0) begin m_phase[c] = 2; m_left[c] = OFFT; end
          end
        end
        default: begin
          if (tick && m_left[c] == 1) begin
            eff = m_q[c] + int'(ev[c]);
            if (eff > 0) begin m_phase[c] = 1; m_left[c] = ONT; m_q[c] = eff - 1; end
            else m_phase[c] = 0;
          end else begin
            if (ev[c]) begin if (m_q[c] < MAXP) m_q[c]++; else drop = 1; end
            if (tick) m_left[c]--;
          end
        end
      endcase
      m_ovf[c] = drop | (m_ovf[c] & ~clr);
    end
  endtask

  function automatic logic [3*CH-1:0] m_exp();
    logic [CH-1:0] l, b;
    for (int c = 0; c < CH; c++) begin
      l[c] = (m_phase[c] == 1);
      b[c] = (m_phase[c] != 0);
    end
    return {l, b, m_ovf};
  endfunction

  // Drive one cycle's inputs at the falling edge, advance the model, move to the next falling edge.
  task automatic step(input logic [CH-1:0] ev, input logic clr);
    i_event = ev; i_clr_ovf = clr;
    model_step(ev, clr);
    @(negedge i_clk);
    i_event = '0; i_clr_ovf = 1'b0;
  endtask

  // Returns at the falling edge that begins cycle 0.
  task automatic apply_reset(input int n);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (n) @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_event = CH'($urandom); i_clr_ovf = 1'(k);
      @(negedge i_clk);
      n_cmp++;
      if ({o_led, o_busy, o_overflow} !== '0) begin
        n_bad++;
        $display("FAIL reset.hold k=%0d got=%h required=0", k, {o_led, o_busy, o_overflow});
      end
    end
    i_event = '0; i_clr_ovf = 1'b0; i_rst_n = 1'b1;
    model_reset();
    n_cmp++;
    if ({o_led, o_busy, o_overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset.release got=%h required=0", {o_led, o_busy, o_overflow});
    end
  endtask

  task automatic test_single();
    apply_reset(2);
    for (int c = 0; c < 25; c++) begin
      n_cmp++;
      if (o_led[0] !== (c >= 2 && c <= 11) || o_busy[0] !== (c >= 2 && c < 20)) begin
        n_bad++;
        $display("FAIL single.timeline c=%0d led=%b busy=%b required led=%b busy=%b",
                 c, o_led[0], o_busy[0], (c >= 2 && c <= 11), (c >= 2 && c < 20));
      end
      step((c == 1) ? CH'(1) : '0, 1'b0);
    end
  endtask

  task automatic test_queued();
    apply_reset(2);
    for (int c = 0; c < 45; c++) begin
      n_cmp++;
      if (o_led[0] !== ((c >= 2 && c <= 11) || (c >= 20 && c <= 31)) || o_busy[0] !== (c >= 2 && c < 40)) begin
        n_bad++;
        $display("FAIL queued.timeline c=%0d led=%b busy=%b", c, o_led[0], o_busy[0]);
      end
      step((c == 1 || c == 5) ? CH'(1) : '0, 1'b0);
    end
  endtask

  // Run 0: drop at 9, second drop at 10 with CLR_OVF (set wins), clear alone at 12.
  task automatic test_overflow();
    bit exp_ovf;
    int rises;
    logic prev;
    for (int run = 0; run < 2; run++) begin
      apply_reset(2);
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 100; c++) begin
        exp_ovf = (c >= 10 && c <= 12);
        n_cmp++;
        if (o_overflow[0] !== exp_ovf) begin
          n_bad++;
          $display("FAIL overflow.flag run=%0d c=%0d got=%b required=%b", run, c, o_overflow[0], exp_ovf);
        end
        if (o_led[0] && !prev) rises++;
        prev = o_led[0];
        step((c == 1 || c == 3 || c == 5 || c == 7 || c == 9 || (run == 0 && c == 10)) ? CH'(1) : '0,
             (run == 0 && c == 10) || c == 12);
      end
      n_cmp++;
      if (rises != 4) begin
        n_bad++;
        $display("FAIL overflow.blinks run=%0d got=%0d required=4", run, rises);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [CH-1:0] exp_led;
    apply_reset(2);
    for (int c = 0; c < 25; c++) begin
      exp_led = (c >= 2 && c <= 11) ? CH'(8'h81) : '0;
      n_cmp++;
      if (o_led !== exp_led) begin
        n_bad++;
        $display("FAIL simul.led c=%0d got=%h required=%h", c, o_led, exp_led);
      end
      step((c == 1) ? CH'(8'h81) : '0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(2);
    for (int c = 0; c < 6; c++) step((c == 1 || c == 5) ? CH'(1) : '0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_led[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid.async led=%b busy=%b required 0/0", o_led[0], o_busy[0]);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 50; c++) begin
      n_cmp++;
      if (o_led !== '0 || o_busy !== '0) begin
        n_bad++;
        $display("FAIL reset_mid.residual c=%0d led=%h busy=%h required 0", c, o_led, o_busy);
      end
      step('0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] ev;
    for (int r = 0; r < 4; r++) begin
      apply_reset(1 + int'($urandom_range(0, 2)));
      for (int c = 0; c < 300; c++) begin
        n_cmp++;
        if ({o_led, o_busy, o_overflow} !== m_exp()) begin
          n_bad++;
          $display("FAIL random.model r=%0d c=%0d got=%h required=%h", r, c, {o_led, o_busy, o_overflow}, m_exp());
        end
        for (int b = 0; b < CH; b++) ev[b] = ($urandom_range(0, (r < 2) ? 3 : 7) == 0);
        step(ev, $urandom_range(0, 19) == 0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_queued();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
